mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the multicycle MIPS datapath, sitting beside the combinational ALU. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width. It holds the HI/LO result registers read by MFHI/MFLO and written by MTHI/MTLO. The control FSM launches an operation with a one-cycle start pulse and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4 and even.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset; one clock domain
- `start`  in  1  launch request; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  WIDTH  rs operand (multiplicand / dividend)
- `b`  in  WIDTH  rt operand (multiplier / divisor)
- `hi_we`, `lo_we`  in  1 each  MTHI / MTLO write enables
- `wdata`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse, HI/LO valid
- `div_by_zero`  out  1  valid with `done`; set for DIV/DIVU with `b`==0
- `hi`, `lo`  out  WIDTH  result registers (MULT: upper/lower product; DIV: remainder/quotient)

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - `start`=1 captures `op`, `a`, `b`.
  - Signed ops store magnitudes plus result sign flags.
  - Next state is MUL, or DIV; DIV/DIVU with `b`==0 go directly to DONE.
- MUL: radix-2 shift-add, one multiplier bit per cycle, WIDTH cycles, 2·WIDTH-bit accumulator. Then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, WIDTH+1-bit partial remainder. Then FIX.
- FIX: applies the sign correction and writes `hi`/`lo`.
  - MULT: negates the 2·WIDTH product when the operand signs differ.
  - DIV: quotient negated when signs differ; remainder takes the dividend's sign, so the quotient truncates toward zero.
  - Next state is DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Overflow case DIV of the most-negative value by -1:
  - `lo`=most-negative value, `hi`=0.
  - No flag; this falls out of the magnitude algorithm.
- Divide by zero:
  - `hi`/`lo` unchanged, `div_by_zero`=1 during `done`.
  - `div_by_zero` clears when the next operation starts.
- `start` outside IDLE is ignored (no queueing).
- MTHI/MTLO:
  - In IDLE with `start`=0, `hi_we`/`lo_we` write `wdata` at the next edge; both may be asserted together.
  - Writes are ignored when `busy`=1 or in DONE.
  - If `start` and a write enable are asserted in the same cycle, `start` wins and the write is dropped.
- `busy` = state ∈ {MUL, DIV, FIX}; `busy`=0 in DONE.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; internal registers 0.
- Reset mid-operation aborts immediately: HI/LO are forced to 0 and no `done` is produced.
- Let `start` be sampled at edge 0:
  - `busy` is high in cycles 1…WIDTH+1.
  - `hi`/`lo` update at edge WIDTH+1 (end of FIX).
  - `done` is high in cycle WIDTH+2; WIDTH=32 gives 34 cycles start-to-done.
- Divide by zero: `busy` never rises; `done` is high in cycle 1.
- A new `start` is accepted at the earliest in cycle WIDTH+3, i.e. the first IDLE cycle after DONE.
- Outputs are registered; there are no combinational paths from inputs to `busy`/`done`/`hi`/`lo`.
- `a`/`b`/`op` need only be valid in the `start` cycle.

## Structure
- Shared package `mips_pkg`:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - state enum type `md_state_t`.
  - The top-level controller also uses these.
- A single sub-module is natural: `twos_abs` (WIDTH-parametrised magnitude/conditional-negate).
  - Instantiated for operand capture and for the FIX correction.
- The FSM and datapath stay in `mult_div_unit`.

## Test plan
1. MULT `a`=0xFFFFFFFF, `b`=0x00000002 -> `done` at cycle 34, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `busy` high cycles 1–33.
2. MULTU same operands -> `hi`=0x00000001, `lo`=0xFFFFFFFE.
3. DIV `a`=0xFFFFFFF9 (-7), `b`=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIVU `a`=100, `b`=7 -> `lo`=14, `hi`=2.
4. DIV `a`=0x80000000, `b`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0, `div_by_zero`=0. Then DIVU `b`=0 -> `done` in cycle 1, `div_by_zero`=1, HI/LO unchanged.
5. MTHI 0x1234 in IDLE -> `hi`=0x1234 next cycle. MTLO and `start` in the same cycle -> `lo` not written. `hi_we` while busy -> ignored. `start` while busy -> ignored, single `done`.
6. `reset` pulsed at cycle 10 of a MULT -> `busy`/`done`/`hi`/`lo`=0 asynchronously. A subsequent MULTU 3×5 -> `lo`=15, `hi`=0 at cycle 34.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle datapath: multiply/divide op
// encodings, the mult/div controller state type and small op decoders.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_twos_abs.sv
// Conditional two's-complement negate: yields |value| when negate is the
// sign bit, or applies a result sign correction.
module twos_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (MTHI/MTLO access).
// Operates on magnitudes, one bit per cycle, then sign-corrects in FIX.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state_r, next_state_s;
    logic               div_op_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opb_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_q_r, neg_r_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r, dbz_r;

    logic               sgn_s, div_s, b_zero_s, last_iter_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [WIDTH-1:0]   div_rem_s, rem_fix_s;
    logic [2*WIDTH-1:0] prod_fix_s;

    assign sgn_s       = md_is_signed(op);
    assign div_s       = md_is_div(op);
    assign b_zero_s    = (b == {WIDTH{1'b0}});
    assign a_neg_s     = sgn_s & a[WIDTH-1];
    assign b_neg_s     = sgn_s & b[WIDTH-1];
    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

    twos_abs #(.WIDTH(WIDTH)) u_a_abs (.value(a), .negate(a_neg_s), .result(a_mag_s));
    twos_abs #(.WIDTH(WIDTH)) u_b_abs (.value(b), .negate(b_neg_s), .result(b_mag_s));

    // Negating the full {rem, quo} word also gives the negated quotient in
    // its lower half, so one 2*WIDTH negator serves both MULT and DIV.
    twos_abs #(.WIDTH(2*WIDTH)) u_prod_fix (.value(acc_r), .negate(neg_q_r), .result(prod_fix_s));
    twos_abs #(.WIDTH(WIDTH)) u_rem_fix (.value(acc_r[2*WIDTH-1:WIDTH]), .negate(neg_r_r), .result(rem_fix_s));

    assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                       + {1'b0, (acc_r[0] ? opb_r : {WIDTH{1'b0}})};
    assign div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opb_r};
    assign div_rem_s   = div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (div_s) begin
                        next_state_s = b_zero_s ? ST_DONE : ST_DIV;
                    end else begin
                        next_state_s = ST_MUL;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL:  next_state_s = last_iter_s ? ST_FIX : ST_MUL;
            ST_DIV:  next_state_s = last_iter_s ? ST_FIX : ST_DIV;
            ST_FIX:  next_state_s = ST_DONE;
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_op_r <= 1'b0;
            acc_r    <= {(2*WIDTH){1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_MUL) || (next_state_s == ST_DIV)
                   || (next_state_s == ST_FIX);
            done_r <= (next_state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        div_op_r <= div_s;
                        cnt_r    <= {CNT_W{1'b0}};
                        dbz_r    <= div_s & b_zero_s;
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= div_s & a_neg_s;
                        // MUL: multiplier sits in the low half; DIV: dividend does.
                        opb_r    <= div_s ? b_mag_s : a_mag_s;
                        acc_r    <= {{WIDTH{1'b0}}, (div_s ? a_mag_s : b_mag_s)};
                    end else begin
                        if (hi_we) begin
                            hi_r <= wdata;
                        end
                        if (lo_we) begin
                            lo_r <= wdata;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                ST_DIV: begin
                    acc_r <= {div_rem_s, acc_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                ST_FIX: begin
                    hi_r <= div_op_r ? rem_fix_s : prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_r <= prod_fix_s[WIDTH-1:0];
                end
                ST_DONE: begin
                    dbz_r <= dbz_r;
                end
                default: begin
                    dbz_r <= dbz_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/div_by_zero are queued at
// launch and compared when done pulses; latency and busy are checked per cycle.
module tb_mult_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         hi_we, lo_we;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    logic [W-1:0] model_hi, model_lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] ch, input logic [W-1:0] cl);
        exp_t r;
        logic signed [63:0] sx, sy, p, q, m;
        logic [63:0] up;
        r.hi = ch; r.lo = cl; r.dbz = 1'b0;
        sx = $signed({{32{x[31]}}, x});
        sy = $signed({{32{y[31]}}, y});
        case (o)
            MD_MULT: begin
                p = sx * sy;
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            MD_MULTU: begin
                up = {32'd0, x} * {32'd0, y};
                r.hi = up[63:32]; r.lo = up[31:0];
            end
            MD_DIV: begin
                if (y == 32'd0) r.dbz = 1'b1;
                else begin
                    q = sx / sy; m = sx % sy;
                    r.lo = q[31:0]; r.hi = m[31:0];
                end
            end
            default: begin
                if (y == 32'd0) r.dbz = 1'b1;
                else begin
                    r.lo = x / y; r.hi = x % y;
                end
            end
        endcase
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check_eq("extra_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
                check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
                check_eq("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
            end
        end
    end

    task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input bit lo_we_with_start, input bit disturb);
        exp_t e;
        int   cyc;
        int   exp_lat;
        e = model(op_i, a_i, b_i, model_hi, model_lo);
        sb_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        lo_we = lo_we_with_start; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        cyc = 1;
        exp_lat = e.dbz ? 1 : W + 2;
        while (!done && cyc < 200) begin
            check_eq("busy", {63'd0, busy}, {63'd0, (cyc <= W + 1) && !e.dbz});
            if (disturb && cyc == 5) begin
                start = 1'b1; op = MD_DIVU; b = 32'd0;
                hi_we = 1'b1; wdata = 32'h5555_AAAA;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; hi_we = 1'b0;
        check_eq("latency", 64'(cyc), 64'(exp_lat));
        check_eq("busy_in_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        model_hi = '0; model_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);

        // MTHI alone, then MTHI+MTLO together
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check_eq("mthi", {32'd0, hi}, 64'h1234);
        check_eq("mthi_lo_kept", {32'd0, lo}, 64'd0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check_eq("mthi_both", {32'd0, hi}, 64'hCAFE_0001);
        check_eq("mtlo_both", {32'd0, lo}, 64'hCAFE_0001);
        model_hi = 32'hCAFE_0001; model_lo = 32'hCAFE_0001;

        run_op(MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        run_op(MD_DIVU,  32'd100,       32'd7,         1'b0, 1'b0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(MD_DIVU,  32'd55,        32'd0,         1'b1, 1'b0);
        check_eq("dbz_held", {63'd0, div_by_zero}, 64'd1);
        check_eq("lo_not_written", {32'd0, lo}, {32'd0, model_lo});
        run_op(MD_DIV,   32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        check_eq("dbz_cleared", {63'd0, div_by_zero}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            r_op = 2'(i % 4);
            r_a  = $urandom;
            if (i == 7)          r_b = 32'd0;
            else if (i % 2 == 1) r_b = 32'($urandom_range(1, 20));
            else                 r_b = $urandom;
            if (i == 5) r_b = -r_b;
            run_op(r_op, r_a, r_b, 1'b0, 1'b0);
        end

        // Reset in the middle of a MULT
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = MD_MULT; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_busy", {63'd0, busy}, 64'd0);
        check_eq("arst_done", {63'd0, done}, 64'd0);
        check_eq("arst_hi", {32'd0, hi}, 64'd0);
        check_eq("arst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
        repeat (40) begin
            @(negedge clk);
            check_eq("no_done_after_reset", {63'd0, done}, 64'd0);
        end
        run_op(MD_MULTU, 32'd3, 32'd5, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
